pc_redirect_unit: RTL and testbench

Program-counter owner and consumer of the branch comparator's decision. Holds the architectural PC and selects the next PC: sequential, branch-taken, JAL, or JALR. Detects misaligned control-flow targets and vectors to a trap address. Drives a valid/ready fetch handshake to instruction memory, and a one-cycle flush pulse to the decode stage on every redirect.

---
 rtl/pc_redirect_unit.sv | 80 ++++++++
 tb/tb_pc_redirect_unit.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit: owns the PC, picks the next fetch address, and raises flush/trap pulses on redirects
module pc_redirect_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_ready,
  input  logic        stall,
  input  logic        bena,
  input  logic        branchsignal,
  input  logic        jal,
  input  logic        jalr,
  input  logic [31:0] imm,
  input  logic [31:0] rs1,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_valid,
  output logic        flush,
  output logic        misalign_trap,
  output logic [31:0] trap_addr
);
  localparam logic [1:0] S_BOOT = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_TRAP = 2'd2;
  logic [1:0]  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_trap_addr;
  logic        r_flush;
  logic        r_trap;
  logic        w_adv;
  logic        w_taken;
  logic        w_redir;
  logic        w_mis;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_jalr_tgt;
  logic [31:0] w_tgt;
  assign w_pc_plus4    = r_pc + 32'd4;
  assign w_adv         = (r_state == S_RUN) & fetch_ready & ~stall;
  assign w_taken       = bena & branchsignal;
  assign w_redir       = jalr | jal | w_taken;
  assign w_jalr_tgt    = (rs1 + imm) & ~32'h1;
  assign pc            = r_pc;
  assign pc_plus4      = w_pc_plus4;
  assign fetch_valid   = (r_state == S_RUN);
  assign flush         = r_flush;
  assign misalign_trap = r_trap;
  assign trap_addr     = r_trap_addr;
  // next-PC select: jalr beats jal beats a taken branch beats fall-through
  always_comb begin
    w_tgt = jalr ? w_jalr_tgt : (jal | w_taken) ? r_pc + imm : w_pc_plus4;
    w_mis = w_redir & w_tgt[1];
  end
  // PC/state update; pulses are registered so they land the cycle after the decision
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_BOOT;
      r_pc        <= RESET_PC;
      r_flush     <= 1'b0;
      r_trap      <= 1'b0;
      r_trap_addr <= 32'h0;
    end else begin
      r_flush <= w_adv & w_redir;
      r_trap  <= w_adv & w_mis;
      if (r_state == S_BOOT) begin
        r_state <= S_RUN;
      end else if (r_state == S_TRAP) begin
        r_pc    <= TRAP_VEC;
        r_state <= S_RUN;
      end else if (r_state != S_RUN) begin
        r_state <= S_BOOT;
      end else if (w_adv && w_mis) begin
        r_trap_addr <= w_tgt;
        r_state     <= S_TRAP;
      end else if (w_adv) begin
        r_pc <= w_tgt;
      end
    end
  end
endmodule

// File: tb/tb_pc_redirect_unit.sv
// tb_pc_redirect_unit: table-driven scoreboard bench for pc_redirect_unit
module tb_pc_redirect_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_ready, stall, bena, branchsignal, jal, jalr;
  logic [31:0] imm, rs1;
  logic [31:0] pc, pc_plus4, trap_addr;
  logic        fetch_valid, flush, misalign_trap;
  int          n_tests = 0;
  int          n_fail  = 0;

  typedef struct {
    logic        fr, st, bena, bs, jal, jalr;
    logic [31:0] imm, rs1, pc;
    logic        fv, fl, tr;
    logic [31:0] ta;
  } vec_t;

  typedef struct {
    logic [31:0] pc, ta;
    logic        fv, fl, tr;
  } exp_t;

  vec_t v[27];
  exp_t q[$];

  pc_redirect_unit dut (
    .clk(clk), .rst(rst), .fetch_ready(fetch_ready), .stall(stall),
    .bena(bena), .branchsignal(branchsignal), .jal(jal), .jalr(jalr),
    .imm(imm), .rs1(rs1), .pc(pc), .pc_plus4(pc_plus4),
    .fetch_valid(fetch_valid), .flush(flush), .misalign_trap(misalign_trap),
    .trap_addr(trap_addr)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  function automatic vec_t mk(input logic fr, st, be, bs, j, jr, input logic [31:0] im, r1, p,
                              input logic fv, fl, tr, input logic [31:0] ta);
    vec_t r;
    r.fr = fr; r.st = st; r.bena = be; r.bs = bs; r.jal = j; r.jalr = jr;
    r.imm = im; r.rs1 = r1; r.pc = p; r.fv = fv; r.fl = fl; r.tr = tr; r.ta = ta;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    fetch_ready = 1'b0; stall = 1'b0; bena = 1'b0; branchsignal = 1'b0;
    jal = 1'b0; jalr = 1'b0; imm = 32'h0; rs1 = 32'h0;
  endtask

  task automatic apply(input int i);
    exp_t e;
    fetch_ready = v[i].fr; stall = v[i].st; bena = v[i].bena; branchsignal = v[i].bs;
    jal = v[i].jal; jalr = v[i].jalr; imm = v[i].imm; rs1 = v[i].rs1;
    e.pc = v[i].pc; e.ta = v[i].ta; e.fv = v[i].fv; e.fl = v[i].fl; e.tr = v[i].tr;
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    check($sformatf("row%0d pc", i), pc, e.pc);
    check($sformatf("row%0d pc_plus4", i), pc_plus4, e.pc + 32'd4);
    check($sformatf("row%0d fetch_valid", i), {31'h0, fetch_valid}, {31'h0, e.fv});
    check($sformatf("row%0d flush", i), {31'h0, flush}, {31'h0, e.fl});
    check($sformatf("row%0d misalign_trap", i), {31'h0, misalign_trap}, {31'h0, e.tr});
    check($sformatf("row%0d trap_addr", i), trap_addr, e.ta);
  endtask

  initial begin
    // fr st be bs jal jalr imm rs1 | pc fv fl tr ta
    v[0]  = mk(1,0,0,0,0,0,32'h0,32'h0,         32'h0,1,0,0,32'h0);
    v[1]  = mk(1,0,0,0,0,0,32'h0,32'h0,         32'h4,1,0,0,32'h0);
    v[2]  = mk(1,0,0,0,0,0,32'h0,32'h0,         32'h8,1,0,0,32'h0);
    v[3]  = mk(1,0,0,0,0,0,32'h0,32'h0,         32'hC,1,0,0,32'h0);
    v[4]  = mk(1,0,0,0,1,0,32'h14,32'h0,        32'h20,1,1,0,32'h0);
    v[5]  = mk(1,0,1,1,0,0,32'hFFFF_FFF0,32'h0, 32'h10,1,1,0,32'h0);
    v[6]  = mk(1,0,0,0,1,0,32'h10,32'h0,        32'h20,1,1,0,32'h0);
    v[7]  = mk(1,0,1,0,0,0,32'hFFFF_FFF0,32'h0, 32'h24,1,0,0,32'h0);
    v[8]  = mk(1,0,0,1,0,0,32'hFFFF_FFF0,32'h0, 32'h28,1,0,0,32'h0);
    v[9]  = mk(1,0,0,0,1,1,32'h4,32'h1001,      32'h1004,1,1,0,32'h0);
    v[10] = mk(1,0,0,0,1,0,32'hFFFF_F03C,32'h0, 32'h40,1,1,0,32'h0);
    v[11] = mk(1,0,0,0,1,0,32'h6,32'h0,         32'h40,0,1,1,32'h46);
    v[12] = mk(1,0,0,0,1,0,32'h80,32'h0,        32'h100,1,0,0,32'h46);
    v[13] = mk(1,0,0,0,1,0,32'hFFFF_FF08,32'h0, 32'h8,1,1,0,32'h46);
    v[14] = mk(0,0,0,0,1,0,32'h80,32'h0,        32'h8,1,0,0,32'h46);
    v[15] = mk(0,0,0,0,1,0,32'h80,32'h0,        32'h8,1,0,0,32'h46);
    v[16] = mk(0,0,0,0,1,0,32'h80,32'h0,        32'h8,1,0,0,32'h46);
    v[17] = mk(1,0,0,0,1,0,32'h80,32'h0,        32'h88,1,1,0,32'h46);
    v[18] = mk(1,0,0,0,1,0,32'hFFFF_FF80,32'h0, 32'h8,1,1,0,32'h46);
    v[19] = mk(1,1,0,0,1,0,32'h80,32'h0,        32'h8,1,0,0,32'h46);
    v[20] = mk(1,1,0,0,1,0,32'h80,32'h0,        32'h8,1,0,0,32'h46);
    v[21] = mk(1,1,0,0,1,0,32'h80,32'h0,        32'h8,1,0,0,32'h46);
    v[22] = mk(1,0,0,0,1,0,32'h80,32'h0,        32'h88,1,1,0,32'h46);
    v[23] = mk(1,0,0,0,0,1,32'h0,32'h102,       32'h88,0,1,1,32'h102);
    v[24] = mk(1,0,0,0,0,0,32'h0,32'h0,         32'h0,1,0,0,32'h0);
    v[25] = mk(1,0,0,0,1,0,32'hFFFF_FFFC,32'h0, 32'hFFFF_FFFC,1,1,0,32'h0);
    v[26] = mk(1,0,0,0,0,0,32'h0,32'h0,         32'h0,1,0,0,32'h0);

    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset pc", pc, 32'h0);
    check("reset fetch_valid", {31'h0, fetch_valid}, 32'h0);
    check("reset flush", {31'h0, flush}, 32'h0);
    check("reset misalign_trap", {31'h0, misalign_trap}, 32'h0);
    check("reset trap_addr", trap_addr, 32'h0);
    rst = 1'b0;
    #1;
    check("boot fetch_valid", {31'h0, fetch_valid}, 32'h0);

    for (int i = 0; i < 24; i++) apply(i);

    // reset lands during the TRAP cycle: must cancel the TRAP_VEC load
    idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midtrap rst pc", pc, 32'h0);
    check("midtrap rst fetch_valid", {31'h0, fetch_valid}, 32'h0);
    check("midtrap rst flush", {31'h0, flush}, 32'h0);
    check("midtrap rst trap", {31'h0, misalign_trap}, 32'h0);
    check("midtrap rst trap_addr", trap_addr, 32'h0);
    rst = 1'b0;

    for (int i = 24; i < 27; i++) apply(i);

    check("scoreboard drained", q.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
